// File: rtl/dbus_pair_arbiter_pkg.sv
// Shared types for the dual-issue data-bus arbiter: FSM states, msize encodings and
// the alignment helper used when DBUS_ALIGN_CHECK_EN is defined.
package dbus_pair_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr1,
    StData1,
    StAddr0,
    StData0,
    StDone
  } arb_state_t;

  localparam logic [2:0] MsizeByte = 3'd0;
  localparam logic [2:0] MsizeHalf = 3'd1;
  localparam logic [2:0] MsizeWord = 3'd2;

  function automatic logic addr_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    return ((size == MsizeHalf) && addr_lo[0]) ||
           ((size == MsizeWord) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dbus_lane_mux.sv
// Steers the active lane's request fields onto the single bus port; lane 1 owns the
// bus in its address/data states, lane 0 otherwise.
module dbus_lane_mux
  import dbus_pair_arbiter_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  arb_state_t        state,
  input  logic [2*AW-1:0]   req_addr,
  input  logic [5:0]        req_size,
  input  logic [7:0]        req_strobe,
  input  logic [2*DW-1:0]   req_wdata,
  output logic [AW-1:0]     bus_addr,
  output logic [2:0]        bus_size,
  output logic [3:0]        bus_strobe,
  output logic [DW-1:0]     bus_wdata
);

  logic sel_lane1;

  assign sel_lane1  = (state == StAddr1) || (state == StData1);

  assign bus_addr   = sel_lane1 ? req_addr[AW +: AW]  : req_addr[0 +: AW];
  assign bus_size   = sel_lane1 ? req_size[3 +: 3]    : req_size[0 +: 3];
  assign bus_strobe = sel_lane1 ? req_strobe[4 +: 4]  : req_strobe[0 +: 4];
  assign bus_wdata  = sel_lane1 ? req_wdata[DW +: DW] : req_wdata[0 +: DW];

endmodule

// File: rtl/dbus_pair_arbiter.sv
// Serializes a same-cycle lane 1 / lane 0 request pair onto one bus port and packs the
// replies as {lane0, lane1}. Optional alignment check: DBUS_ALIGN_CHECK_EN.
module dbus_pair_arbiter
  import dbus_pair_arbiter_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        req_valid,
  input  logic [2*AW-1:0]   req_addr,
  input  logic [5:0]        req_size,
  input  logic [7:0]        req_strobe,
  input  logic [2*DW-1:0]   req_wdata,
  input  logic              advance,
  output logic              bus_valid,
  output logic [AW-1:0]     bus_addr,
  output logic [2:0]        bus_size,
  output logic [3:0]        bus_strobe,
  output logic [DW-1:0]     bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DW-1:0]     bus_rdata,
  output logic [2*DW-1:0]   rdata,
  output logic              data_ok,
  output logic              stall
`ifdef DBUS_ALIGN_CHECK_EN
  ,
  output logic [1:0]        misalign
`endif
);

  arb_state_t      state_q, state_d;
  logic [2*DW-1:0] rdata_q, rdata_d;
  logic [1:0]      issue;  // lanes that actually go out on the bus

`ifdef DBUS_ALIGN_CHECK_EN
  logic [1:0] lane_mis;
  logic [1:0] misalign_q, misalign_d;

  assign lane_mis[1] = addr_misaligned(req_size[3 +: 3], req_addr[AW +: 2]);
  assign lane_mis[0] = addr_misaligned(req_size[0 +: 3], req_addr[0 +: 2]);
  assign issue       = req_valid & ~lane_mis;
  assign misalign    = misalign_q;
`else
  assign issue = req_valid;
`endif

  dbus_lane_mux #(
    .AW (AW),
    .DW (DW)
  ) u_lane_mux (
    .state      (state_q),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_strobe (req_strobe),
    .req_wdata  (req_wdata),
    .bus_addr   (bus_addr),
    .bus_size   (bus_size),
    .bus_strobe (bus_strobe),
    .bus_wdata  (bus_wdata)
  );

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    bus_valid = 1'b0;
    data_ok   = 1'b0;
    stall     = 1'b1;
`ifdef DBUS_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    unique case (state_q)
      StIdle: begin
        stall = |req_valid;
        if (issue[1]) begin
          state_d = StAddr1;
        end else if (issue[0]) begin
          state_d = StAddr0;
        end else if (|req_valid) begin
          state_d = StDone;  // every valid lane was rejected as misaligned
        end
`ifdef DBUS_ALIGN_CHECK_EN
        if (req_valid[1] && lane_mis[1]) begin
          misalign_d[1]     = 1'b1;
          rdata_d[0 +: DW]  = '0;
        end
        if (req_valid[0] && lane_mis[0]) begin
          misalign_d[0]     = 1'b1;
          rdata_d[DW +: DW] = '0;
        end
`endif
      end
      StAddr1: begin
        bus_valid = 1'b1;
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            rdata_d[0 +: DW] = bus_rdata;
            state_d          = issue[0] ? StAddr0 : StDone;
          end else begin
            state_d = StData1;
          end
        end
      end
      StData1: begin
        if (bus_data_ok) begin
          rdata_d[0 +: DW] = bus_rdata;
          state_d          = issue[0] ? StAddr0 : StDone;
        end
      end
      StAddr0: begin
        bus_valid = 1'b1;
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            rdata_d[DW +: DW] = bus_rdata;
            state_d           = StDone;
          end else begin
            state_d = StData0;
          end
        end
      end
      StData0: begin
        if (bus_data_ok) begin
          rdata_d[DW +: DW] = bus_rdata;
          state_d           = StDone;
        end
      end
      StDone: begin
        stall   = 1'b0;
        data_ok = 1'b1;
        if (advance) begin
          state_d = StIdle;
`ifdef DBUS_ALIGN_CHECK_EN
          misalign_d = '0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      rdata_q <= '0;
`ifdef DBUS_ALIGN_CHECK_EN
      misalign_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
`ifdef DBUS_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign rdata = rdata_q;

endmodule

// File: doc/dbus_pair_arbiter.md
Name: dbus_pair_arbiter

Overview:
- Sits between the dual-issue memory-request stage and the single-port data bus.
- Accepts up to two same-cycle load/store requests, lane 1 older and lane 0 younger, and serializes them onto one bus port, lane 1 first.
- Captures each lane's read data and presents both as one 64-bit word: lane 1 in [31:0], lane 0 in [63:32], which is the layout the load-extraction stage downstream consumes.
- Raises a stall until both lanes' responses are held.

Parameters:
- AW, 32, address width.
- DW, 32, per-lane data width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  2  per-lane request valid, held stable while stall=1
- req_addr  in  2xAW  per-lane byte address
- req_size  in  2x3  per-lane access size (msize encoding: 0=byte, 1=half, 2=word)
- req_strobe  in  2x4  per-lane byte write strobe (0 = load)
- req_wdata  in  2xDW  per-lane write data
- advance  in  1  pipeline accepts the current result this cycle
- bus_valid  out  1  bus request valid
- bus_addr  out  AW  bus address
- bus_size  out  3  bus access size
- bus_strobe  out  4  bus write strobe
- bus_wdata  out  DW  bus write data
- bus_addr_ok  in  1  bus accepted the address phase
- bus_data_ok  in  1  bus data phase complete
- bus_rdata  in  DW  bus read data
- rdata  out  2xDW  {lane0, lane1} captured read data
- data_ok  out  1  both lanes' results are held
- stall  out  1  request pair not yet complete

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE; bus_valid=0; rdata=0; data_ok=0; stall=0. Reset mid-transaction abandons any outstanding beat; a data_ok arriving later is ignored.
- States: IDLE, ADDR1, DATA1, ADDR0, DATA0, DONE.
- IDLE:
  - req_valid[1] → ADDR1.
  - else req_valid[0] → ADDR0.
  - else stay IDLE.
  - stall is asserted combinationally in the same cycle any req_valid is 1.
- ADDR1 / ADDR0: bus_valid=1, bus fields driven from that lane.
  - On bus_addr_ok → DATA1 / DATA0.
  - If bus_data_ok arrives in the same cycle as bus_addr_ok, skip the DATA state: capture the data and advance as DATA would.
- DATA1: bus_valid=0. On bus_data_ok:
  - capture bus_rdata into rdata[0] (bits [31:0]);
  - → ADDR0 if req_valid[0], else → DONE.
- DATA0: on bus_data_ok, capture bus_rdata into rdata[1] (bits [63:32]) → DONE.
- DONE: data_ok=1, stall=0.
  - If advance → IDLE.
  - Without advance, hold DONE and rdata indefinitely.
- Bus request fields must stay stable while bus_valid=1 and addr_ok=0.
- A lane with req_valid=0 leaves its rdata half unchanged from the last capture.
- Store beats capture data too; the value is don't-care but data_ok timing is identical.
- Minimum latency for two lanes with single-cycle addr_ok+data_ok: 2 cycles busy, DONE on cycle 3.
- No new request pair is accepted while state≠IDLE.

Optional Feature:
- Macro: DBUS_ALIGN_CHECK_EN.
- Enabled:
  - A lane whose address is misaligned for its size (half with addr[0]=1; word with addr[1:0]≠0) is never issued on the bus.
  - Its rdata half is written 0 and an extra output misalign[1:0] is set for it.
  - misalign resets to 0, is valid in DONE, and clears on advance.
  - If lane 1 is misaligned, lane 0 is still issued.
- Disabled: the misalign port is absent; all requests are issued unchecked.

Decomposition:
- Shared package (common.svh): arb_state_t enum and the msize encodings.
- Existing dbus_req_t / dbus_resp_t may wrap the bus port.
- One natural sub-module: dbus_lane_mux, which selects the active lane's addr/size/strobe/wdata from the state.

Test Plan:
- Both lanes load: addr 0x100 → 0xAAAA5555, addr 0x104 → 0x12345678; addr_ok and data_ok each one cycle → rdata=0x12345678_AAAA5555, data_ok in cycle 3, stall high for cycles 1–2.
- Only lane 0 valid (addr 0x200 → 0xDEADBEEF) → one bus beat, rdata[63:32]=0xDEADBEEF, rdata[31:0] unchanged.
- Bus delays addr_ok 3 cycles for lane 1 → bus_addr / bus_strobe stable throughout, stall held, lane 0 issued only after lane 1's data_ok.
- DONE held with advance=0 for 4 cycles → rdata and data_ok stable; advance=1 → IDLE next cycle, data_ok=0.
- resetn=0 during DATA1, bus_data_ok arriving one cycle later → state IDLE, data_ok=0, rdata=0, no capture.
- With DBUS_ALIGN_CHECK_EN: lane 1 word at 0x102, lane 0 word at 0x108 → only 0x108 on the bus, misalign=2'b10, rdata[31:0]=0.
